// File: rtl/seq_addsub32_pkg.sv
// Shared definitions for the iterative slice-serial adder/subtractor.
// Holds default sizing and the FSM state encoding.
package seq_addsub32_pkg;

    localparam int WIDTH_DEFAULT      = 32;
    localparam int SLICE_DEFAULT      = 4;
    localparam int NUM_SLICES_DEFAULT = WIDTH_DEFAULT / SLICE_DEFAULT;

    // The encoding 2'd3 is unused and falls back to IDLE in the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_addsub32_slice_add4.sv
// Combinational 4-bit lookahead adder slice.
// Also exposes the carry into bit 3 so the top can derive signed overflow.
module slice_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/seq_addsub32.sv
// Iterative adder/subtractor: resolves one SLICE-bit slice per cycle through a
// single shared slice_add4, with valid/ready handshakes on both sides.
module seq_addsub32
    import seq_addsub32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_cout;
    logic             slice_c3;

    assign slice_a = a_reg[index*SLICE +: SLICE];
    assign slice_b = b_reg[index*SLICE +: SLICE];

    slice_add4 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // B is pre-inverted and the carry seeded with sub, so subtraction reuses
    // the same add path; on the last slice the MSB carries give cout/ovf.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= data_a;
                        b_reg <= data_b ^ {WIDTH{sub}};
                        carry <= sub;
                        index <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[index*SLICE +: SLICE] <= slice_s;
                    carry <= slice_cout;
                    if (index == LAST_IDX) begin
                        index <= '0;
                        cout  <= slice_cout;
                        ovf   <= slice_c3 ^ slice_cout;
                        state <= DONE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
